updown_counter_param: RTL and testbench

Parametrised synchronous up/down counter. Successor to the fixed 4-bit up/down counter in the datapath library. Adds the following over the fixed version:
- configurable width and modulus
- parallel load and synchronous clear
- wrap or saturate mode
- registered carry/borrow terminal pulses and a zero flag

Used as the loop and index counter in the controller datapaths and as a building block for timers.

---
 rtl/updown_counter_param_pkg.sv | 26 ++
 rtl/updown_counter_param_if.sv | 28 ++
 rtl/updown_counter_param_counter_step.sv | 63 ++++++
 rtl/updown_counter_param.sv | 82 ++++++++
 tb/tb_updown_counter_param.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/updown_counter_param_pkg.sv
// Shared definitions for the parametrised up/down counter.
//   MODE_WRAP / MODE_SAT : sat_mode encodings (wrap at bounds / saturate at bounds)
//   sel_e                : next-state select used by the top-level register mux
//   sel_next()           : priority encode of clr > ld_en > count
package updown_counter_param_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    typedef enum logic [1:0] {
        SelCount = 2'd0,
        SelLoad  = 2'd1,
        SelClr   = 2'd2
    } sel_e;

    // Reset is handled by the register itself; this only orders the in-service sources.
    function automatic sel_e sel_next(input logic clr, input logic ld_en);
        if (clr) begin
            return SelClr;
        end else if (ld_en) begin
            return SelLoad;
        end
        return SelCount;
    endfunction

endpackage

// File: rtl/updown_counter_param_if.sv
// Control/data bundle for updown_counter_param.
//   master : drives clr, ld_en, par_in, up_cnt_en, down_cnt_en, sat_mode;
//            observes par_out, carry_out, borrow_out, zero
//   slave  : the counter side of the same signals
interface updown_counter_param_if #(
    parameter int unsigned WIDTH = 8
);
    logic             clr;
    logic             ld_en;
    logic [WIDTH-1:0] par_in;
    logic             up_cnt_en;
    logic             down_cnt_en;
    logic             sat_mode;
    logic [WIDTH-1:0] par_out;
    logic             carry_out;
    logic             borrow_out;
    logic             zero;

    modport master (
        output clr, ld_en, par_in, up_cnt_en, down_cnt_en, sat_mode,
        input  par_out, carry_out, borrow_out, zero
    );

    modport slave (
        input  clr, ld_en, par_in, up_cnt_en, down_cnt_en, sat_mode,
        output par_out, carry_out, borrow_out, zero
    );
endinterface

// File: rtl/updown_counter_param_counter_step.sv
// Combinational single step of the counter.
//   i_cur      : current count
//   i_max_val  : terminal count
//   i_up       : increment request
//   i_down     : decrement request
//   i_sat_mode : MODE_WRAP or MODE_SAT
//   o_nxt      : next count
//   o_carry    : up-step attempted at i_max_val
//   o_borrow   : down-step attempted at zero
module updown_counter_param_counter_step
    import updown_counter_param_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_cur,
    input  logic [WIDTH-1:0] i_max_val,
    input  logic             i_up,
    input  logic             i_down,
    input  logic             i_sat_mode,
    output logic [WIDTH-1:0] o_nxt,
    output logic             o_carry,
    output logic             o_borrow
);

    logic             w_up_only;
    logic             w_down_only;
    logic             w_at_max;
    logic             w_at_zero;
    logic [WIDTH-1:0] w_addend;
    logic [WIDTH-1:0] w_sum;

    assign w_up_only   = i_up & ~i_down;
    assign w_down_only = i_down & ~i_up;
    assign w_at_max    = (i_cur == i_max_val);
    assign w_at_zero   = (i_cur == '0);

    // One adder serves both directions: +1, or all-ones as two's-complement -1.
    assign w_addend = w_down_only ? '1 : WIDTH'(w_up_only);
    assign w_sum    = i_cur + w_addend;

    // Bounds are handled explicitly so a non-power-of-2 modulus wraps at i_max_val.
    always_comb begin
        o_nxt    = i_cur;
        o_carry  = 1'b0;
        o_borrow = 1'b0;
        if (w_up_only) begin
            if (w_at_max) begin
                o_carry = 1'b1;
                o_nxt   = (i_sat_mode == MODE_SAT) ? i_max_val : '0;
            end else begin
                o_nxt = w_sum;
            end
        end else if (w_down_only) begin
            if (w_at_zero) begin
                o_borrow = 1'b1;
                o_nxt    = (i_sat_mode == MODE_SAT) ? '0 : i_max_val;
            end else begin
                o_nxt = w_sum;
            end
        end
    end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised synchronous up/down counter with load, clear, wrap/saturate modes.
//   i_clk   : rising-edge clock
//   i_rst_n : synchronous active-low reset (overrides everything)
//   bus     : slave side of updown_counter_param_if
//             (clr, ld_en, par_in, up_cnt_en, down_cnt_en, sat_mode in;
//              par_out, carry_out, borrow_out registered out; zero combinational out)
module updown_counter_param
    import updown_counter_param_pkg::*;
#(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input logic                  i_clk,
    input logic                  i_rst_n,
    updown_counter_param_if.slave bus
);

    logic [WIDTH-1:0] r_count;
    logic             r_carry;
    logic             r_borrow;

    sel_e             w_sel;
    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH-1:0] w_step_nxt;
    logic             w_step_carry;
    logic             w_step_borrow;

    assign w_sel      = sel_next(bus.clr, bus.ld_en);
    // Out-of-range loads clamp to the terminal count.
    assign w_load_val = (bus.par_in > MAX_VAL) ? MAX_VAL : bus.par_in;

    updown_counter_param_counter_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_cur      (r_count),
        .i_max_val  (MAX_VAL),
        .i_up       (bus.up_cnt_en),
        .i_down     (bus.down_cnt_en),
        .i_sat_mode (bus.sat_mode),
        .o_nxt      (w_step_nxt),
        .o_carry    (w_step_carry),
        .o_borrow   (w_step_borrow)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count  <= RST_VAL;
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
        end else begin
            unique case (w_sel)
                SelClr: begin
                    r_count  <= RST_VAL;
                    r_carry  <= 1'b0;
                    r_borrow <= 1'b0;
                end
                SelLoad: begin
                    r_count  <= w_load_val;
                    r_carry  <= 1'b0;
                    r_borrow <= 1'b0;
                end
                SelCount: begin
                    r_count  <= w_step_nxt;
                    r_carry  <= w_step_carry;
                    r_borrow <= w_step_borrow;
                end
                default: begin
                    r_count  <= r_count;
                    r_carry  <= 1'b0;
                    r_borrow <= 1'b0;
                end
            endcase
        end
    end

    assign bus.par_out    = r_count;
    assign bus.carry_out  = r_carry;
    assign bus.borrow_out = r_borrow;
    assign bus.zero       = (r_count == '0);

endmodule

// File: tb/tb_updown_counter_param.sv
module tb_updown_counter_param;

    typedef struct packed {
        logic       rst_n;
        logic       clr;
        logic       ld;
        logic [7:0] par;
        logic       up;
        logic       dn;
        logic       sat;
    } stim_t;

    typedef struct packed {
        logic [7:0] cnt;
        logic       carry;
        logic       borrow;
        logic       zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    updown_counter_param_if #(.WIDTH(4)) ifa ();
    updown_counter_param_if #(.WIDTH(8)) ifb ();

    updown_counter_param #(
        .WIDTH   (4),
        .MAX_VAL (4'd9),
        .RST_VAL (4'd0)
    ) dut_a (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (ifa)
    );

    updown_counter_param #(
        .WIDTH (8)
    ) dut_b (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (ifb)
    );

    function automatic stim_t mk(bit r, bit c, bit l, int p, bit u, bit d, bit s);
        stim_t x;
        x.rst_n = r;
        x.clr   = c;
        x.ld    = l;
        x.par   = 8'(p);
        x.up    = u;
        x.dn    = d;
        x.sat   = s;
        return x;
    endfunction

    function automatic exp_t ev(int cnt, bit c, bit b);
        exp_t e;
        e.cnt    = 8'(cnt);
        e.carry  = c;
        e.borrow = b;
        e.zero   = (cnt == 0);
        return e;
    endfunction

    task automatic apply_a(input stim_t s);
        rst_n           = s.rst_n;
        ifa.clr         = s.clr;
        ifa.ld_en       = s.ld;
        ifa.par_in      = s.par[3:0];
        ifa.up_cnt_en   = s.up;
        ifa.down_cnt_en = s.dn;
        ifa.sat_mode    = s.sat;
    endtask

    task automatic apply_b(input stim_t s);
        rst_n           = s.rst_n;
        ifb.clr         = s.clr;
        ifb.ld_en       = s.ld;
        ifb.par_in      = s.par;
        ifb.up_cnt_en   = s.up;
        ifb.down_cnt_en = s.dn;
        ifb.sat_mode    = s.sat;
    endtask

    function automatic exp_t sample_a();
        exp_t g;
        g.cnt    = {4'b0, ifa.par_out};
        g.carry  = ifa.carry_out;
        g.borrow = ifa.borrow_out;
        g.zero   = ifa.zero;
        return g;
    endfunction

    function automatic exp_t sample_b();
        exp_t g;
        g.cnt    = ifb.par_out;
        g.carry  = ifb.carry_out;
        g.borrow = ifb.borrow_out;
        g.zero   = ifb.zero;
        return g;
    endfunction

    task automatic test_reset();
        exp_t got;
        exp_t want;
        apply_a(mk(0, 0, 0, 0, 1, 0, 0));
        apply_b(mk(0, 0, 0, 0, 0, 1, 0));
        sb.push_back(ev(0, 0, 0));
        sb.push_back(ev(0, 0, 0));
        @(posedge clk);
        #1;
        got  = sample_a();
        want = sb.pop_front();
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL reset_a: got cnt=%0d c=%b b=%b z=%b, expected cnt=%0d c=%b b=%b z=%b",
                     got.cnt, got.carry, got.borrow, got.zero,
                     want.cnt, want.carry, want.borrow, want.zero);
        end
        got  = sample_b();
        want = sb.pop_front();
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL reset_b: got cnt=%0d c=%b b=%b z=%b, expected cnt=%0d c=%b b=%b z=%b",
                     got.cnt, got.carry, got.borrow, got.zero,
                     want.cnt, want.carry, want.borrow, want.zero);
        end
    endtask

    task automatic test_wrap_up();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  got;
        exp_t  want;
        for (int i = 0; i < 12; i++) begin
            st.push_back(mk(1, 0, 0, 0, 1, 0, 0));
            ex.push_back(ev((i + 1) % 10, i == 9, 0));
        end
        for (int i = 0; i < st.size(); i++) begin
            apply_a(st[i]);
            sb.push_back(ex[i]);
            @(posedge clk);
            #1;
            got  = sample_a();
            want = sb.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL wrap_up[%0d]: got cnt=%0d c=%b b=%b z=%b, expected cnt=%0d c=%b b=%b z=%b",
                         i, got.cnt, got.carry, got.borrow, got.zero,
                         want.cnt, want.carry, want.borrow, want.zero);
            end
        end
    endtask

    task automatic test_sat_up();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  got;
        exp_t  want;
        st.push_back(mk(1, 0, 1, 8, 0, 0, 1)); ex.push_back(ev(8, 0, 0));
        st.push_back(mk(1, 0, 0, 0, 1, 0, 1)); ex.push_back(ev(9, 0, 0));
        st.push_back(mk(1, 0, 0, 0, 1, 0, 1)); ex.push_back(ev(9, 1, 0));
        st.push_back(mk(1, 0, 0, 0, 1, 0, 1)); ex.push_back(ev(9, 1, 0));
        st.push_back(mk(1, 0, 0, 0, 0, 0, 1)); ex.push_back(ev(9, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            apply_a(st[i]);
            sb.push_back(ex[i]);
            @(posedge clk);
            #1;
            got  = sample_a();
            want = sb.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL sat_up[%0d]: got cnt=%0d c=%b b=%b z=%b, expected cnt=%0d c=%b b=%b z=%b",
                         i, got.cnt, got.carry, got.borrow, got.zero,
                         want.cnt, want.carry, want.borrow, want.zero);
            end
        end
    endtask

    task automatic test_down_from_zero();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  got;
        exp_t  want;
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0)); ex.push_back(ev(0, 0, 0));
        st.push_back(mk(1, 0, 0, 0, 0, 1, 0)); ex.push_back(ev(9, 0, 1));
        st.push_back(mk(1, 0, 0, 0, 0, 1, 0)); ex.push_back(ev(8, 0, 0));
        st.push_back(mk(0, 0, 0, 0, 0, 0, 1)); ex.push_back(ev(0, 0, 0));
        st.push_back(mk(1, 0, 0, 0, 0, 1, 1)); ex.push_back(ev(0, 0, 1));
        st.push_back(mk(1, 0, 0, 0, 0, 0, 1)); ex.push_back(ev(0, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            apply_a(st[i]);
            sb.push_back(ex[i]);
            @(posedge clk);
            #1;
            got  = sample_a();
            want = sb.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL down_zero[%0d]: got cnt=%0d c=%b b=%b z=%b, expected cnt=%0d c=%b b=%b z=%b",
                         i, got.cnt, got.carry, got.borrow, got.zero,
                         want.cnt, want.carry, want.borrow, want.zero);
            end
        end
    endtask

    task automatic test_priority();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  got;
        exp_t  want;
        st.push_back(mk(1, 0, 1, 5, 0, 0, 0));  ex.push_back(ev(5, 0, 0));
        st.push_back(mk(1, 1, 1, 7, 1, 0, 0));  ex.push_back(ev(0, 0, 0));
        st.push_back(mk(1, 0, 1, 12, 0, 0, 0)); ex.push_back(ev(9, 0, 0));
        st.push_back(mk(1, 0, 0, 0, 1, 1, 0));  ex.push_back(ev(9, 0, 0));
        st.push_back(mk(1, 0, 1, 3, 1, 0, 0));  ex.push_back(ev(3, 0, 0));
        st.push_back(mk(1, 0, 0, 0, 1, 0, 1));  ex.push_back(ev(4, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            apply_a(st[i]);
            sb.push_back(ex[i]);
            @(posedge clk);
            #1;
            got  = sample_a();
            want = sb.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL priority[%0d]: got cnt=%0d c=%b b=%b z=%b, expected cnt=%0d c=%b b=%b z=%b",
                         i, got.cnt, got.carry, got.borrow, got.zero,
                         want.cnt, want.carry, want.borrow, want.zero);
            end
        end
    endtask

    task automatic test_reset_mid();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  got;
        exp_t  want;
        st.push_back(mk(1, 0, 1, 5, 0, 0, 0)); ex.push_back(ev(5, 0, 0));
        st.push_back(mk(1, 0, 0, 0, 1, 0, 0)); ex.push_back(ev(6, 0, 0));
        st.push_back(mk(0, 0, 0, 0, 1, 0, 0)); ex.push_back(ev(0, 0, 0));
        st.push_back(mk(0, 0, 0, 0, 0, 1, 0)); ex.push_back(ev(0, 0, 0));
        st.push_back(mk(0, 0, 1, 7, 1, 0, 1)); ex.push_back(ev(0, 0, 0));
        st.push_back(mk(1, 0, 1, 9, 0, 0, 0)); ex.push_back(ev(9, 0, 0));
        st.push_back(mk(1, 0, 0, 0, 1, 0, 0)); ex.push_back(ev(0, 1, 0));
        st.push_back(mk(0, 0, 0, 0, 1, 0, 0)); ex.push_back(ev(0, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            apply_a(st[i]);
            sb.push_back(ex[i]);
            @(posedge clk);
            #1;
            got  = sample_a();
            want = sb.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL reset_mid[%0d]: got cnt=%0d c=%b b=%b z=%b, expected cnt=%0d c=%b b=%b z=%b",
                         i, got.cnt, got.carry, got.borrow, got.zero,
                         want.cnt, want.carry, want.borrow, want.zero);
            end
        end
    endtask

    task automatic test_w8_wrap();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  got;
        exp_t  want;
        apply_a(mk(1, 0, 0, 0, 0, 0, 0));
        st.push_back(mk(1, 0, 1, 254, 0, 0, 0)); ex.push_back(ev(254, 0, 0));
        st.push_back(mk(1, 0, 0, 0, 1, 0, 0));   ex.push_back(ev(255, 0, 0));
        st.push_back(mk(1, 0, 0, 0, 1, 0, 0));   ex.push_back(ev(0, 1, 0));
        st.push_back(mk(1, 0, 0, 0, 0, 1, 0));   ex.push_back(ev(255, 0, 1));
        st.push_back(mk(1, 0, 0, 0, 0, 0, 0));   ex.push_back(ev(255, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            apply_b(st[i]);
            sb.push_back(ex[i]);
            @(posedge clk);
            #1;
            got  = sample_b();
            want = sb.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL w8_wrap[%0d]: got cnt=%0d c=%b b=%b z=%b, expected cnt=%0d c=%b b=%b z=%b",
                         i, got.cnt, got.carry, got.borrow, got.zero,
                         want.cnt, want.carry, want.borrow, want.zero);
            end
        end
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_sat_up();
        test_down_from_zero();
        test_priority();
        test_reset_mid();
        test_w8_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
